// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: opcodes, FSM states and access-size helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MERGE = 2'd1,
        ST_RESP  = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    function automatic lsu_size_e op_size(input lsu_op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic op_is_store(input lsu_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_signed(input lsu_op_e op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic misaligned(input lsu_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane handling: extracts/extends a load lane and merges a store lane into a word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  lsu_size_e   size_i,
    input  logic        sign_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    assign shamt = {offset_i, 3'b000};

    // Byte offset 0 lives in [31:24], so shifting left brings the addressed lane to the top.
    always_comb begin
        shifted   = word_i << shamt;
        load_o    = word_i;
        lane_mask = '1;
        lane_data = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o    = sign_i ? {{24{shifted[31]}}, shifted[31:24]}
                                   : {24'h000000, shifted[31:24]};
                lane_mask = 32'hFF00_0000 >> shamt;
                lane_data = {wdata_i[7:0], 24'h000000} >> shamt;
            end
            SZ_HALF: begin
                load_o    = sign_i ? {{16{shifted[31]}}, shifted[31:16]}
                                   : {16'h0000, shifted[31:16]};
                lane_mask = 32'hFFFF_0000 >> shamt;
                lane_data = {wdata_i[15:0], 16'h0000} >> shamt;
            end
            default: begin
                load_o    = word_i;
                lane_mask = '1;
                lane_data = wdata_i;
            end
        endcase
        merge_o = (word_i & ~lane_mask) | (lane_data & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a big-endian word memory with a
// combinational read port; sub-word stores use a read-capture then merge-write cycle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEMORY_SIZE = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] LAST_WORD = 32'(MEMORY_SIZE - 4);

    lsu_state_e  state_q, state_d;
    lsu_op_e     req_op;
    logic [31:0] req_waddr;
    logic        req_fault;
    logic        accept;

    logic [31:0] word_q, wdata_q, waddr_q, rdata_q;
    logic [1:0]  off_q;
    lsu_size_e   size_q;
    logic        fault_q;

    logic        in_merge;
    logic [31:0] al_word, al_wdata, al_load, al_merge;
    logic [1:0]  al_off;
    lsu_size_e   al_size;

    assign req_op    = lsu_op_e'(op);
    assign req_waddr = {addr[31:2], 2'b00};
    assign req_fault = misaligned(op_size(req_op), addr[1:0]) || (req_waddr > LAST_WORD);
    assign accept    = (state_q == ST_IDLE) && req_valid;

    // One aligner serves both the live load path and the captured-word merge path.
    assign in_merge = (state_q == ST_MERGE);
    assign al_word  = in_merge ? word_q  : mem_rdata;
    assign al_off   = in_merge ? off_q   : addr[1:0];
    assign al_size  = in_merge ? size_q  : op_size(req_op);
    assign al_wdata = in_merge ? wdata_q : wdata;

    lsu_lane_align u_align (
        .word_i   (al_word),
        .offset_i (al_off),
        .size_i   (al_size),
        .sign_i   (op_is_signed(req_op)),
        .wdata_i  (al_wdata),
        .load_o   (al_load),
        .merge_o  (al_merge)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_fault && (req_op == OP_SB || req_op == OP_SH)) state_d = ST_MERGE;
                    else                                                    state_d = ST_RESP;
                end
            end
            ST_MERGE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Memory-side outputs are forced to zero while reset is held, including mid-MERGE.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        fault      = fault_q && (state_q == ST_RESP);
        rdata      = rdata_q;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_write  = 1'b0;
        if (rst) begin
            case (state_q)
                ST_IDLE: begin
                    mem_addr  = req_waddr;
                    mem_wdata = wdata;
                    mem_write = req_valid && (req_op == OP_SW) && !req_fault;
                end
                ST_MERGE: begin
                    mem_addr  = waddr_q;
                    mem_wdata = al_merge;
                    mem_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            fault_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            off_q   <= '0;
            size_q  <= SZ_BYTE;
        end else if (accept) begin
            rdata_q <= (req_fault || op_is_store(req_op)) ? '0 : al_load;
            fault_q <= req_fault;
            word_q  <= mem_rdata;
            wdata_q <= wdata;
            waddr_q <= req_waddr;
            off_q   <= addr[1:0];
            size_q  <= op_size(req_op);
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit against a byte-array reference of the memory.
module tb_load_store_unit;

    localparam int MEM = 64;
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                           LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk, rst, req_valid, req_ready, resp_valid, fault, mem_write;
    logic [2:0]  op;
    logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:15];
    logic [7:0]  ref_b [0:63];
    logic        bd_we;
    logic [3:0]  bd_idx;
    logic [31:0] bd_val;

    int chk_cnt = 0;
    int pass_cnt = 0;

    load_store_unit #(.MEMORY_SIZE(MEM)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .fault      (fault),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < MEM) ? mem[mem_addr[5:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_val;
        else if (mem_write && mem_addr < MEM) mem[mem_addr[5:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic preload(input int i, input logic [31:0] v);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = i[3:0]; bd_val = v;
        @(posedge clk);
        #1 bd_we = 1'b0;
        for (int b = 0; b < 4; b++) ref_b[4*i+b] = v[31-8*b -: 8];
    endtask

    // Reference: byte-addressed memory, big-endian words, spec fault and latency rules.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic flt, output int lat, output int wr);
        int sz;
        logic [63:0] v;
        sz  = (o == LB || o == LBU || o == SB) ? 1 : (o == LH || o == LHU || o == SH) ? 2 : 4;
        flt = ((a % sz) != 0) || ((a - (a % 4)) > MEM - 4);
        rd = 0; lat = 1; wr = 0;
        if (!flt) begin
            if (o < SB) begin
                v = 0;
                for (int i = 0; i < sz; i++) v = (v << 8) | 64'(ref_b[a+i]);
                if ((o == LB || o == LH) && v[8*sz-1]) v = v - (64'd1 << (8*sz));
                rd = v[31:0];
            end else begin
                for (int i = 0; i < sz; i++) ref_b[a+i] = wd[8*(sz-1-i) +: 8];
                lat = (sz == 4) ? 1 : 2;
                wr  = 1;
            end
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                         input bit hold, output logic [31:0] rd, output logic flt,
                         output int lat, output int wr_acc, output int wr_tot,
                         output logic [31:0] wr_addr);
        @(negedge clk);
        op = o; addr = a; wdata = wd; req_valid = 1'b1;
        #1;
        check("ready", 32'(req_ready), 32'd1);
        check("no_resp", 32'(resp_valid), 32'd0);
        check("acc_addr", mem_addr, {a[31:2], 2'b00});
        wr_acc = int'(mem_write); wr_tot = wr_acc; wr_addr = mem_write ? mem_addr : 32'hFFFF_FFFF;
        lat = 0; rd = '0; flt = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            #1;
            if (mem_write) begin wr_tot++; wr_addr = mem_addr; end
            if (resp_valid) begin
                lat = c; rd = rdata; flt = fault; req_valid = 1'b0;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                       input bit hold, output logic [31:0] rd, output logic flt);
        logic [31:0] e_rd, wa;
        logic        e_flt;
        int          e_lat, e_wr, lat, wr_acc, wr_tot;
        model(o, a, wd, e_rd, e_flt, e_lat, e_wr);
        issue(o, a, wd, hold, rd, flt, lat, wr_acc, wr_tot, wa);
        check("latency", 32'(lat), 32'(e_lat));
        check("fault", 32'(flt), 32'(e_flt));
        check("rdata", rd, e_rd);
        check("wr_at_accept", 32'(wr_acc), (o == SW && !e_flt) ? 32'd1 : 32'd0);
        check("wr_count", 32'(wr_tot), 32'(e_wr));
        if (e_wr != 0) check("wr_addr", wa, {a[31:2], 2'b00});
    endtask

    initial begin
        logic [31:0] rd, a;
        logic        flt;
        int          resp_seen;
        rst = 1'b0; req_valid = 1'b1; op = SW; addr = 32'h10; wdata = 32'hFFFF_FFFF;
        bd_we = 1'b0; bd_idx = '0; bd_val = '0;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        @(negedge clk); #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp", 32'(resp_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;

        preload(1, 32'h1284_5678);
        run(LB, 32'h5, 32'h0, 1'b0, rd, flt);
        check("lb_sext", rd, 32'hFFFF_FF84);
        run(LBU, 32'h5, 32'h0, 1'b0, rd, flt);
        check("lbu_zext", rd, 32'h0000_0084);

        preload(1, 32'h1122_3344);
        run(SH, 32'h6, 32'h0000_BEEF, 1'b0, rd, flt);
        @(negedge clk);
        check("sh_merge_word", mem[1], 32'h1122_BEEF);

        run(LW, 32'h2, 32'h0, 1'b0, rd, flt);
        check("lw_misalign", 32'(flt), 32'd1);
        run(LW, 32'h3C, 32'h0, 1'b0, rd, flt);
        check("lw_last_word", 32'(flt), 32'd0);
        run(LW, 32'h40, 32'h0, 1'b0, rd, flt);
        check("lw_out_of_range", 32'(flt), 32'd1);

        run(SW, 32'h8, 32'hCAFE_F00D, 1'b0, rd, flt);
        run(LW, 32'h8, 32'h0, 1'b0, rd, flt);
        check("sw_then_lw", rd, 32'hCAFE_F00D);

        run(SW, 32'h10, $urandom, 1'b1, rd, flt);
        run(SH, 32'h12, $urandom, 1'b1, rd, flt);
        run(SB, 32'h17, $urandom, 1'b1, rd, flt);

        preload(0, 32'hA5A5_A5A5);
        @(negedge clk);
        op = SB; addr = 32'h1; wdata = 32'h3C; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        check("merge_write", 32'(mem_write), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_write", 32'(mem_write), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_addr", mem_addr, 32'd0);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        resp_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (resp_valid) resp_seen++;
        end
        check("abort_no_resp", 32'(resp_seen), 32'd0);
        check("abort_mem", mem[0], 32'hA5A5_A5A5);
        check("abort_rdata", rdata, 32'd0);

        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) a = $urandom;
            else a = 32'($urandom_range(0, 32'h43));
            if (r >= 6) a = a & ~32'h3;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(3'($urandom_range(0, 7)), a, $urandom, 1'($urandom_range(0, 1)), rd, flt);
        end

        @(negedge clk);
        for (int i = 0; i < 16; i++)
            check("mem_final", mem[i], {ref_b[4*i], ref_b[4*i+1], ref_b[4*i+2], ref_b[4*i+3]});

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
